// File: rtl/gba_lcd_pkg.sv
// Shared constants, the RGB555 pixel type, state encoding and the framebuffer
// address helper for the GBA LCD transmitter.
package gba_lcd_pkg;

    localparam int WIDTH  = 240;
    localparam int HEIGHT = 160;
    localparam int HTOTAL = 308;
    localparam int VTOTAL = 228;
    localparam int PIX_W  = 15;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } rgb555_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } lcd_state_t;

    // Raster-order word address of pixel (h, v); the line pitch defaults to WIDTH.
    function automatic logic [15:0] pix_addr(input logic [7:0]  v,
                                             input logic [8:0]  h,
                                             input logic [15:0] w = 16'(WIDTH));
        return (16'(v) * w) + 16'(h);
    endfunction

endpackage

// File: rtl/gba_lcd_timing.sv
// Slot prescaler, h/v raster counters, IDLE/RUN control and panel timing strobes.
// Strobes are registered from the next counter values so they line up with the slot.
module gba_lcd_timing #(
    parameter int WIDTH   = gba_lcd_pkg::WIDTH,
    parameter int HEIGHT  = gba_lcd_pkg::HEIGHT,
    parameter int HTOTAL  = gba_lcd_pkg::HTOTAL,
    parameter int VTOTAL  = gba_lcd_pkg::VTOTAL,
    parameter int CLK_DIV = 4,
    parameter int PW      = $clog2(CLK_DIV)
) (
    input  logic          o_wrclk,
    input  logic          i_rst,
    input  logic          i_en,
    output logic          o_run,
    output logic [PW-1:0] o_p,
    output logic [8:0]    o_h,
    output logic [7:0]    o_v,
    output logic          o_DCLK,
    output logic          o_LP,
    output logic          o_SPL,
    output logic          o_CLS,
    output logic          o_SPS,
    output logic          o_MOD,
    output logic          o_VCOM,
    output logic          o_frame_done
);
    import gba_lcd_pkg::*;

    localparam logic [PW-1:0] P_ZERO     = {PW{1'b0}};
    localparam logic [PW-1:0] P_LAST     = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_HALF     = PW'(CLK_DIV / 2);
    localparam logic [8:0]    H_ACT      = 9'(WIDTH);
    localparam logic [8:0]    H_LP_END   = 9'(WIDTH + 1);
    localparam logic [8:0]    H_PIX_LAST = 9'(WIDTH - 1);
    localparam logic [8:0]    H_PRE_LAST = 9'(HTOTAL - 2);
    localparam logic [8:0]    H_LAST     = 9'(HTOTAL - 1);
    localparam logic [7:0]    V_ACT      = 8'(HEIGHT);
    localparam logic [7:0]    V_PIX_LAST = 8'(HEIGHT - 1);
    localparam logic [7:0]    V_LAST     = 8'(VTOTAL - 1);

    lcd_state_t    r_state, w_state_n;
    logic [PW-1:0] r_p, w_p_n;
    logic [8:0]    r_h, w_h_n;
    logic [7:0]    r_v, w_v_n;
    logic          w_p_last, w_run_n, w_act_n, w_lp_n;
    logic          r_dclk, r_lp, r_spl, r_cls, r_sps, r_mod, r_vcom, r_frame_done;

    // Next state and counter values; the stop request is only honoured at the
    // end of slot (HTOTAL-2, VTOTAL-1) so a started frame always completes.
    always_comb begin
        w_state_n = r_state;
        w_p_n     = r_p;
        w_h_n     = r_h;
        w_v_n     = r_v;
        w_p_last  = (r_p == P_LAST);
        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    w_state_n = ST_RUN;
                    w_p_n     = P_ZERO;
                    w_h_n     = H_LAST;
                    w_v_n     = V_LAST;
                end else begin
                    w_p_n = P_ZERO;
                    w_h_n = 9'd0;
                    w_v_n = 8'd0;
                end
            end
            ST_RUN: begin
                if (w_p_last && (r_h == H_PRE_LAST) && (r_v == V_LAST) && !i_en) begin
                    w_state_n = ST_IDLE;
                    w_p_n     = P_ZERO;
                    w_h_n     = 9'd0;
                    w_v_n     = 8'd0;
                end else if (w_p_last) begin
                    w_p_n = P_ZERO;
                    if (r_h == H_LAST) begin
                        w_h_n = 9'd0;
                        w_v_n = (r_v == V_LAST) ? 8'd0 : (r_v + 8'd1);
                    end else begin
                        w_h_n = r_h + 9'd1;
                    end
                end else begin
                    w_p_n = r_p + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_p_n     = P_ZERO;
                w_h_n     = 9'd0;
                w_v_n     = 8'd0;
            end
        endcase
    end

    // Region decode of the upcoming slot.
    always_comb begin
        w_run_n = (w_state_n == ST_RUN);
        w_act_n = w_run_n && (w_h_n < H_ACT) && (w_v_n < V_ACT);
        w_lp_n  = w_run_n && ((w_h_n == H_ACT) || (w_h_n == H_LP_END));
    end

    // Counter, state and strobe registers.
    always_ff @(posedge o_wrclk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_p          <= P_ZERO;
            r_h          <= 9'd0;
            r_v          <= 8'd0;
            r_dclk       <= 1'b0;
            r_lp         <= 1'b0;
            r_spl        <= 1'b0;
            r_cls        <= 1'b0;
            r_sps        <= 1'b0;
            r_mod        <= 1'b0;
            r_vcom       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_p          <= w_p_n;
            r_h          <= w_h_n;
            r_v          <= w_v_n;
            r_dclk       <= w_act_n && (w_p_n >= P_HALF);
            r_lp         <= w_lp_n;
            r_spl        <= w_run_n && (w_h_n == H_LAST) &&
                            ((w_v_n == V_LAST) || (w_v_n < V_PIX_LAST));
            r_cls        <= w_run_n && (w_v_n < V_ACT);
            r_sps        <= w_run_n && (w_v_n == 8'd0) && (w_h_n < 9'd2);
            r_frame_done <= w_run_n && (w_p_n == P_LAST) &&
                            (w_h_n == H_PIX_LAST) && (w_v_n == V_PIX_LAST);
            if (!w_run_n) begin
                r_mod <= 1'b0;
            end else if ((w_p_n == P_ZERO) && (w_h_n == 9'd0) && (w_v_n == 8'd0)) begin
                r_mod <= ~r_mod;
            end else begin
                r_mod <= r_mod;
            end
            // VCOM follows the LP rising edge of the same slot.
            if (!w_run_n) begin
                r_vcom <= 1'b0;
            end else if (w_lp_n && !r_lp) begin
                r_vcom <= ~r_vcom;
            end else begin
                r_vcom <= r_vcom;
            end
        end
    end

    assign o_run        = (r_state == ST_RUN);
    assign o_p          = r_p;
    assign o_h          = r_h;
    assign o_v          = r_v;
    assign o_DCLK       = r_dclk;
    assign o_LP         = r_lp;
    assign o_SPL        = r_spl;
    assign o_CLS        = r_cls;
    assign o_SPS        = r_sps;
    assign o_MOD        = r_mod;
    assign o_VCOM       = r_vcom;
    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/gba_lcd_tx.sv
// GBA LCD transmitter: prefetches each pixel one slot ahead and drives panel RGB.
// Define GBA_LCD_TX_TESTPAT_EN to replace the RAM path with 8 vertical colour bars.
module gba_lcd_tx #(
    parameter int WIDTH   = gba_lcd_pkg::WIDTH,
    parameter int HEIGHT  = gba_lcd_pkg::HEIGHT,
    parameter int HTOTAL  = gba_lcd_pkg::HTOTAL,
    parameter int VTOTAL  = gba_lcd_pkg::VTOTAL,
    parameter int CLK_DIV = 4
) (
    input  logic        o_wrclk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [15:0] o_rdaddr,
    output logic        o_rden,
    input  logic [14:0] i_rddata,
    output logic        o_DCLK,
    output logic        o_LP,
    output logic        o_SPL,
    output logic        o_CLS,
    output logic        o_SPS,
    output logic        o_MOD,
    output logic        o_VCOM,
    output logic [4:0]  o_R,
    output logic [4:0]  o_G,
    output logic [4:0]  o_B,
    output logic        o_frame_done
);
    import gba_lcd_pkg::*;

    localparam int            PW     = $clog2(CLK_DIV);
    localparam logic [PW-1:0] P_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [8:0]    H_ACT  = 9'(WIDTH);
    localparam logic [8:0]    H_LAST = 9'(HTOTAL - 1);
    localparam logic [7:0]    V_ACT  = 8'(HEIGHT);
    localparam logic [7:0]    V_LAST = 8'(VTOTAL - 1);

    logic          w_run;
    logic [PW-1:0] w_p;
    logic [8:0]    w_h, w_hx;
    logic [7:0]    w_v, w_vx;
    logic          w_nx_act;
    rgb555_t       w_pix;
    rgb555_t       r_rgb;
    logic [15:0]   r_rdaddr;
    logic          r_rden;

    gba_lcd_timing #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .HTOTAL  (HTOTAL),
        .VTOTAL  (VTOTAL),
        .CLK_DIV (CLK_DIV),
        .PW      (PW)
    ) u_timing (
        .o_wrclk      (o_wrclk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .o_run        (w_run),
        .o_p          (w_p),
        .o_h          (w_h),
        .o_v          (w_v),
        .o_DCLK       (o_DCLK),
        .o_LP         (o_LP),
        .o_SPL        (o_SPL),
        .o_CLS        (o_CLS),
        .o_SPS        (o_SPS),
        .o_MOD        (o_MOD),
        .o_VCOM       (o_VCOM),
        .o_frame_done (o_frame_done)
    );

    // Coordinates of the slot after the current one, i.e. the pixel being fetched.
    always_comb begin
        if (w_h == H_LAST) begin
            w_hx = 9'd0;
            w_vx = (w_v == V_LAST) ? 8'd0 : (w_v + 8'd1);
        end else begin
            w_hx = w_h + 9'd1;
            w_vx = w_v;
        end
        w_nx_act = w_run && (w_hx < H_ACT) && (w_vx < V_ACT);
    end

`ifdef GBA_LCD_TX_TESTPAT_EN
    localparam logic       PREFETCH_EN = 1'b0;
    localparam logic [8:0] H_BAR       = 9'(WIDTH / 8);
    logic [2:0] w_bar;

    // Bar colour: each index bit drives one full-scale channel.
    always_comb begin
        w_bar   = 3'(w_hx / H_BAR);
        w_pix.r = {5{w_bar[2]}};
        w_pix.g = {5{w_bar[1]}};
        w_pix.b = {5{w_bar[0]}};
    end
`else
    localparam logic PREFETCH_EN = 1'b1;
    assign w_pix = rgb555_t'(i_rddata);
`endif

    // One-cycle read strobe at the start of the slot preceding each active pixel.
    always_ff @(posedge o_wrclk) begin
        if (i_rst) begin
            r_rdaddr <= 16'd0;
            r_rden   <= 1'b0;
        end else if (!w_run) begin
            r_rdaddr <= 16'd0;
            r_rden   <= 1'b0;
        end else if ((w_p == P_ZERO) && w_nx_act) begin
            r_rdaddr <= pix_addr(w_vx, w_hx, 16'(WIDTH));
            r_rden   <= PREFETCH_EN;
        end else begin
            r_rden   <= 1'b0;
        end
    end

    // Latch at the last cycle of the preceding slot so colour is stable for the whole pixel.
    always_ff @(posedge o_wrclk) begin
        if (i_rst) begin
            r_rgb <= '0;
        end else if (!w_run) begin
            r_rgb <= '0;
        end else if (w_p == P_LAST) begin
            r_rgb <= w_nx_act ? w_pix : '0;
        end else begin
            r_rgb <= r_rgb;
        end
    end

    assign o_rdaddr = r_rdaddr;
    assign o_rden   = r_rden;
    assign o_R      = r_rgb.r;
    assign o_G      = r_rgb.g;
    assign o_B      = r_rgb.b;

endmodule

// File: tb/tb_gba_lcd_tx.sv
// Directed bench for gba_lcd_tx on a reduced raster (16x6 active, 22x9 total, 4 cycles/slot).
`timescale 1ns/1ps
module tb_gba_lcd_tx;

    localparam int TW        = 16;
    localparam int TH        = 6;
    localparam int THT       = 22;
    localparam int TVT       = 9;
    localparam int TCD       = 4;
    localparam int LINE_CYC  = THT * TCD;
    localparam int FRAME_CYC = LINE_CYC * TVT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] rdaddr;
    logic        rden;
    logic [14:0] rddata = 15'd0;
    logic        dclk, lp, spl, cls, sps, mod_s, vcom, frame_done;
    logic [4:0]  r, g, b;

    int n_tests = 0;
    int n_fail  = 0;

    gba_lcd_tx #(
        .WIDTH(TW), .HEIGHT(TH), .HTOTAL(THT), .VTOTAL(TVT), .CLK_DIV(TCD)
    ) dut (
        .o_wrclk(clk), .i_rst(rst), .i_en(en),
        .o_rdaddr(rdaddr), .o_rden(rden), .i_rddata(rddata),
        .o_DCLK(dclk), .o_LP(lp), .o_SPL(spl), .o_CLS(cls), .o_SPS(sps),
        .o_MOD(mod_s), .o_VCOM(vcom), .o_R(r), .o_G(g), .o_B(b),
        .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency RAM whose word n holds n.
    always @(posedge clk) begin
        if (rden) rddata <= rdaddr[14:0];
    end

    function automatic logic [39:0] all_outs();
        return {rdaddr, rden, dclk, lp, spl, cls, sps, mod_s, vcom, r, g, b, frame_done};
    endfunction

    // Runs until frame_done, counting DCLK rises and colours that differ from the raster index.
    task automatic run_frame(output int rises, output int bad, output int dones,
                             output logic [14:0] bad_act, output logic [14:0] bad_exp,
                             output bit timeout);
        logic pd;
        rises = 0; bad = 0; dones = 0; bad_act = 15'd0; bad_exp = 15'd0; timeout = 1'b1;
        pd = dclk;
        for (int i = 0; i < FRAME_CYC + 2 * LINE_CYC; i++) begin
            @(negedge clk);
            if (dclk && !pd) begin
                if ({r, g, b} !== 15'(rises)) begin
                    if (bad == 0) begin
                        bad_act = {r, g, b};
                        bad_exp = 15'(rises);
                    end
                    bad++;
                end
                rises++;
            end
            pd = dclk;
            if (frame_done) begin
                dones++;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_sps_rise(output bit found);
        logic ps;
        found = 1'b0;
        ps = sps;
        for (int i = 0; i < FRAME_CYC + LINE_CYC; i++) begin
            @(negedge clk);
            if (sps && !ps) begin
                found = 1'b1;
                break;
            end
            ps = sps;
        end
    endtask

    task automatic test_reset();
        int w;
        rst = 1'b1;
        en  = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if (all_outs() !== 40'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        rst = 1'b0;
`ifdef GBA_LCD_TX_TESTPAT_EN
        w = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rden) w++;
        end
        n_tests++;
        if (w != 0) begin
            n_fail++; $display("FAIL reset_no_rden: rden cycles %0d want 0", w);
        end
`else
        w = 0;
        while (!rden && w < 2) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (rden !== 1'b1) begin
            n_fail++; $display("FAIL first_rden: rden %b after %0d cycles want 1", rden, w);
        end
        n_tests++;
        if (rdaddr !== 16'd0) begin
            n_fail++; $display("FAIL first_rdaddr: got %0d want 0", rdaddr);
        end
        @(negedge clk);
        n_tests++;
        if (rden !== 1'b0) begin
            n_fail++; $display("FAIL rden_single_cycle: got %b want 0", rden);
        end
`endif
    endtask

    task automatic test_frame();
        int rises, bad, dones;
        logic [14:0] ba, be;
        bit to;
        run_frame(rises, bad, dones, ba, be, to);
        n_tests++;
        if (to) begin
            n_fail++; $display("FAIL frame_timeout: frame_done not seen");
        end
        n_tests++;
        if (rises != TW * TH) begin
            n_fail++; $display("FAIL frame_dclk_rises: got %0d want %0d", rises, TW * TH);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL frame_pixels: %0d bad, first got %0d want %0d", bad, ba, be);
        end
        @(negedge clk);
        n_tests++;
        if (frame_done !== 1'b0) begin
            n_fail++; $display("FAIL frame_done_pulse: got %b want 0", frame_done);
        end
    endtask

    task automatic test_timing();
        logic p_lp, p_sps, p_spl, p_mod, p_vcom, lp_r, sps_r;
        int lp_rises = 0, lp_gap_bad = 0, last_lp = -1;
        int sps_rises = 0, first_sps = 0, sps_gap = 0;
        int cls_cyc = 0, spl_rises = 0, mod_on = 0, mod_stray = 0;
        int vcom_on = 0, vcom_stray = 0, dclk_blank = 0;
        @(negedge clk);
        p_lp = lp; p_sps = sps; p_spl = spl; p_mod = mod_s; p_vcom = vcom;
        for (int t = 0; t < 2 * FRAME_CYC + 10; t++) begin
            @(negedge clk);
            lp_r  = lp && !p_lp;
            sps_r = sps && !p_sps;
            if (lp_r) begin
                if (last_lp >= 0 && (t - last_lp) != LINE_CYC) lp_gap_bad++;
                last_lp = t;
                lp_rises++;
            end
            if (sps_r) begin
                sps_rises++;
                if (sps_rises == 1) first_sps = t;
                else if (sps_rises == 2) sps_gap = t - first_sps;
            end
            if (sps_rises == 1) begin
                if (cls) cls_cyc++;
                if (spl && !p_spl) spl_rises++;
            end
            if (mod_s != p_mod) begin
                if (sps_r) mod_on++; else mod_stray++;
            end
            if (vcom != p_vcom) begin
                if (lp_r) vcom_on++; else vcom_stray++;
            end
            if (dclk && (!cls || lp)) dclk_blank++;
            p_lp = lp; p_sps = sps; p_spl = spl; p_mod = mod_s; p_vcom = vcom;
        end
        n_tests++;
        if (lp_rises < 2 * TVT) begin
            n_fail++; $display("FAIL lp_count: got %0d want >= %0d", lp_rises, 2 * TVT);
        end
        n_tests++;
        if (lp_gap_bad != 0) begin
            n_fail++; $display("FAIL lp_spacing: %0d gaps not %0d cycles", lp_gap_bad, LINE_CYC);
        end
        n_tests++;
        if (sps_rises != 2) begin
            n_fail++; $display("FAIL sps_count: got %0d want 2", sps_rises);
        end
        n_tests++;
        if (sps_gap != FRAME_CYC) begin
            n_fail++; $display("FAIL sps_spacing: got %0d want %0d", sps_gap, FRAME_CYC);
        end
        n_tests++;
        if (cls_cyc != TH * LINE_CYC) begin
            n_fail++; $display("FAIL cls_high: got %0d cycles want %0d", cls_cyc, TH * LINE_CYC);
        end
        n_tests++;
        if (spl_rises != TH) begin
            n_fail++; $display("FAIL spl_per_frame: got %0d want %0d", spl_rises, TH);
        end
        n_tests++;
        if (mod_on != sps_rises || mod_stray != 0) begin
            n_fail++; $display("FAIL mod_toggle: at frame start %0d, elsewhere %0d, want %0d/0",
                               mod_on, mod_stray, sps_rises);
        end
        n_tests++;
        if (vcom_on != lp_rises || vcom_stray != 0) begin
            n_fail++; $display("FAIL vcom_toggle: on lp %0d, elsewhere %0d, want %0d/0",
                               vcom_on, vcom_stray, lp_rises);
        end
        n_tests++;
        if (dclk_blank != 0) begin
            n_fail++; $display("FAIL dclk_blanking: got %0d cycles want 0", dclk_blank);
        end
    endtask

    task automatic test_stop();
        int k, rises_after, dones, rden_after;
        bit found;
        logic pd;
        wait_sps_rise(found);
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL stop_wait_sps: no frame start seen");
        end
        k = 0; found = 1'b0; pd = dclk;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            if (dclk && !pd) begin
                if (k == 3 * TW + 10) begin
                    en = 1'b0;
                    found = 1'b1;
                end
                k++;
            end
            pd = dclk;
            if (found) break;
        end
        rises_after = 0; dones = 0; rden_after = 0;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            @(negedge clk);
            if (dclk && !pd) rises_after++;
            pd = dclk;
            if (dones > 0 && rden) rden_after++;
            if (frame_done) dones++;
        end
        n_tests++;
        if (rises_after != TW * TH - (3 * TW + 10) - 1) begin
            n_fail++; $display("FAIL stop_rest_of_frame: got %0d rises want %0d",
                               rises_after, TW * TH - (3 * TW + 10) - 1);
        end
        n_tests++;
        if (dones != 1) begin
            n_fail++; $display("FAIL stop_frame_done: got %0d want 1", dones);
        end
        n_tests++;
        if (rden_after != 0) begin
            n_fail++; $display("FAIL stop_no_rden: got %0d want 0", rden_after);
        end
        n_tests++;
        if (all_outs() !== 40'd0) begin
            n_fail++; $display("FAIL stop_idle_outputs: got %h want 0", all_outs());
        end
    endtask

    task automatic test_reset_mid();
        int k, rises, bad, dones;
        logic [14:0] ba, be;
        bit found, to;
        logic pd;
        en = 1'b1;
        wait_sps_rise(found);
        k = 0; pd = dclk; found = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            if (dclk && !pd) begin
                if (k == 4 * TW + 8) found = 1'b1;
                k++;
            end
            pd = dclk;
            if (found) break;
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (all_outs() !== 40'd0 || !found) begin
            n_fail++; $display("FAIL midreset_outputs: got %h want 0 (reached %b)", all_outs(), found);
        end
        rst = 1'b0;
        run_frame(rises, bad, dones, ba, be, to);
        n_tests++;
        if (to || rises != TW * TH) begin
            n_fail++; $display("FAIL midreset_restart: rises %0d timeout %b want %0d/0", rises, to, TW * TH);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL midreset_pixels: %0d bad, first got %0d want %0d", bad, ba, be);
        end
    endtask

    task automatic test_testpat();
        int k, rden_seen;
        logic [14:0] c0, c1, c2;
        bit done;
        logic pd;
        k = 0; rden_seen = 0; done = 1'b0;
        c0 = 15'h7fff; c1 = 15'h7fff; c2 = 15'd0;
        pd = dclk;
        for (int i = 0; i < FRAME_CYC + 2 * LINE_CYC; i++) begin
            @(negedge clk);
            if (rden) rden_seen++;
            if (dclk && !pd) begin
                if (k == 0) c0 = {r, g, b};
                if (k == TW / 8) c1 = {r, g, b};
                if (k == TW - 1) c2 = {r, g, b};
                k++;
            end
            pd = dclk;
            if (frame_done) begin
                done = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!done || rden_seen != 0) begin
            n_fail++; $display("FAIL testpat_rden: rden cycles %0d done %b want 0/1", rden_seen, done);
        end
        n_tests++;
        if (c0 !== 15'd0) begin
            n_fail++; $display("FAIL testpat_bar0: got %h want 0000", c0);
        end
        n_tests++;
        if (c1 !== 15'h001f) begin
            n_fail++; $display("FAIL testpat_bar1: got %h want 001f", c1);
        end
        n_tests++;
        if (c2 !== 15'h7fff) begin
            n_fail++; $display("FAIL testpat_bar7: got %h want 7fff", c2);
        end
    endtask

    initial begin
        test_reset();
`ifdef GBA_LCD_TX_TESTPAT_EN
        test_testpat();
        test_timing();
`else
        test_frame();
        test_timing();
        test_stop();
        test_reset_mid();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
